mac_seq_ctrl: RTL and testbench

Sequencer that time-shares one combinational multiply-accumulate datapath (acc + a*b) across a stream of operand pairs to compute a dot product of programmable length. It accepts operands over a valid/ready stream and owns the accumulator register. It drives the shared datapath's operand and accumulator inputs and captures its result each accepted term. The finished sum, with a sticky overflow flag, is returned over a valid/ready output.

---
 rtl/mac_seq_ctrl_if.sv | 31 +++
 rtl/mac_seq_ctrl.sv | 69 ++++++
 tb/tb_mac_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: operand stream, result stream and shared MAC datapath bus
// master: drives operands, consumes results, implements the datapath (mac_res)
// slave : the sequencer; accepts operands, drives datapath inputs, returns result
interface mac_seq_ctrl_if #(
    parameter int A_W   = 2,
    parameter int B_W   = 3,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic [A_W-1:0]   mac_a;
    logic [B_W-1:0]   mac_b;
    logic [ACC_W-1:0] mac_acc;
    logic [ACC_W:0]   mac_res;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready, mac_res,
        input  in_ready, mac_a, mac_b, mac_acc, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mac_res,
        output in_ready, mac_a, mac_b, mac_acc, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: dot-product sequencer time-sharing one external acc + a*b datapath
// clk, rst_n       : clock, async active-low reset
// start, len,      : launch a job of len terms seeded with acc_init (sampled in IDLE)
// acc_init
// clear            : sync abort back to IDLE, zeroing acc/cnt/ovf
// busy             : high in RUN or DONE
// bus (slave)      : operand stream in, datapath drive/capture, result stream out
module mac_seq_ctrl #(
    parameter int A_W   = 2,
    parameter int B_W   = 3,
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] len,
    input  logic [ACC_W-1:0] acc_init,
    output logic             busy,
    mac_seq_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= acc_init;
                    cnt   <= len;
                    ovf   <= 1'b0;
                    state <= len != '0 ? RUN : DONE;
                end
                RUN: if (bus.in_valid) begin
                    acc <= bus.mac_res[ACC_W-1:0];
                    ovf <= ovf | bus.mac_res[ACC_W];
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state == RUN;
    assign bus.out_valid = state == DONE;
    assign bus.out_data  = bus.out_valid ? acc : '0;
    assign bus.out_ovf   = bus.out_valid & ovf;
    assign busy          = state != IDLE;
    assign bus.mac_a     = bus.in_ready ? bus.in_a : '0;
    assign bus.mac_b     = bus.in_ready ? bus.in_b : '0;
    assign bus.mac_acc   = acc;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;
    localparam int A_W = 2, B_W = 3, ACC_W = 8, CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic [CNT_W-1:0] len;
    logic [ACC_W-1:0] acc_init;
    logic             busy;
    int               checks = 0;
    int               errors = 0;

    mac_seq_ctrl_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus ();

    mac_seq_ctrl #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .len(len), .acc_init(acc_init), .busy(busy), .bus(bus.slave)
    );

    // behavioural shared datapath
    assign bus.mac_res = (ACC_W+1)'(bus.mac_acc) + (ACC_W+1)'(bus.mac_a) * (ACC_W+1)'(bus.mac_b);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [CNT_W-1:0] l, input logic [ACC_W-1:0] init);
        start = 1'b1; len = l; acc_init = init;
        tick();
        start = 1'b0; len = '0; acc_init = '0;
    endtask

    task automatic term(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        tick();
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    endtask

    task automatic expect_done(input string tag, input logic [ACC_W-1:0] d, input logic o);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(o));
        chk({tag, "_inrdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_data"}, 32'(bus.out_data), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; len = '0; acc_init = '0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        #3;
        chk("rst_inrdy", 32'(bus.in_ready), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_macacc", 32'(bus.mac_acc), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // back-to-back terms: 21 + 10 + 1 = 32
        start_job(4'd3, 8'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_inrdy", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_a = 2'd3; bus.in_b = 3'd7;
        #1;
        chk("t1_maca", 32'(bus.mac_a), 32'd3);
        chk("t1_macb", 32'(bus.mac_b), 32'd7);
        chk("t1_macacc", 32'(bus.mac_acc), 32'd0);
        tick();
        bus.in_a = 2'd2; bus.in_b = 3'd5;
        tick();
        chk("t1_macacc2", 32'(bus.mac_acc), 32'd31);
        bus.in_a = 2'd1; bus.in_b = 3'd1;
        tick();
        bus.in_valid = 1'b0;
        expect_done("t1", 8'd32, 1'b0);
        handshake("t1");

        // gaps between terms
        start_job(4'd3, 8'd0);
        term(2'd3, 3'd7);
        for (int i = 0; i < 2; i++) begin
            chk("t2_gap_inrdy", 32'(bus.in_ready), 32'd1);
            tick();
        end
        term(2'd2, 3'd5);
        for (int i = 0; i < 2; i++) begin
            chk("t2_gap_valid", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("t2_macacc", 32'(bus.mac_acc), 32'd31);
        term(2'd1, 3'd1);
        expect_done("t2", 8'd32, 1'b0);
        handshake("t2");

        // overflow: 250 + 21 = 0x10F, then sticky cleared on next start
        start_job(4'd1, 8'd250);
        term(2'd3, 3'd7);
        expect_done("t3", 8'd15, 1'b1);
        handshake("t3");
        start_job(4'd1, 8'd0);
        term(2'd1, 3'd1);
        expect_done("t3b", 8'd1, 1'b0);
        handshake("t3b");

        // zero-length job
        start = 1'b1; len = 4'd0; acc_init = 8'h5A;
        #1;
        chk("t4_start_inrdy", 32'(bus.in_ready), 32'd0);
        tick();
        start = 1'b0;
        expect_done("t4", 8'h5A, 1'b0);
        handshake("t4");

        // hold in DONE while pulsing start; start during handshake ignored
        start_job(4'd1, 8'd0);
        term(2'd2, 3'd3);
        for (int i = 0; i < 5; i++) begin
            start = ~start; len = 4'd2; acc_init = 8'd99;
            tick();
            chk("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t5_hold_data", 32'(bus.out_data), 32'd6);
            chk("t5_hold_ovf", 32'(bus.out_ovf), 32'd0);
        end
        start = 1'b1; len = 4'd1; acc_init = 8'd5; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_valid", 32'(bus.out_valid), 32'd0);
        tick();
        start = 1'b0; len = '0; acc_init = '0;
        chk("t5_restart_inrdy", 32'(bus.in_ready), 32'd1);
        term(2'd1, 3'd1);
        expect_done("t5", 8'd6, 1'b0);
        handshake("t5");

        // clear mid-run
        start_job(4'd3, 8'd0);
        term(2'd3, 3'd7);
        chk("t6a_macacc_pre", 32'(bus.mac_acc), 32'd21);
        clear = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 2'd1; bus.in_b = 3'd1;
        tick();
        clear = 1'b0; bus.in_valid = 1'b0;
        chk("t6a_busy", 32'(busy), 32'd0);
        chk("t6a_macacc", 32'(bus.mac_acc), 32'd0);
        chk("t6a_inrdy", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t6a_valid", 32'(bus.out_valid), 32'd0);

        // async reset mid-run, no clock edge needed
        start_job(4'd3, 8'd10);
        term(2'd1, 3'd1);
        bus.in_valid = 1'b1; bus.in_a = 2'd3; bus.in_b = 3'd7;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_inrdy", 32'(bus.in_ready), 32'd0);
        chk("t6b_macacc", 32'(bus.mac_acc), 32'd0);
        chk("t6b_maca", 32'(bus.mac_a), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_job(4'd1, 8'd0);
        term(2'd3, 3'd5);
        expect_done("t6b", 8'd15, 1'b0);
        handshake("t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
